mpadd_seq: RTL and testbench

Multi-precision add/subtract sequencer that sits directly upstream of the 64-bit pipelined CLA adder. It accepts LIMBS×64-bit operands through a valid/ready handshake and issues them to the adder one 64-bit limb at a time, chaining the carry between limbs. It collects the limb sums and returns the full-width sum, carry-out and signed overflow through a second valid/ready handshake.

---
 rtl/mpadd_pkg.sv | 7 +
 rtl/mpadd_limb_sel.sv | 12 +
 rtl/mpadd_seq.sv | 116 +++++++++++
 tb/tb_mpadd_seq.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mpadd_pkg.sv
// mpadd_pkg: shared constants, FSM state and op encodings for the multi-precision add sequencer.
package mpadd_pkg;
    localparam int LIMB_W = 64;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;
endpackage

// File: rtl/mpadd_limb_sel.sv
// mpadd_limb_sel: combinational select of 64-bit limb k from a LIMBS-limb vector.
module mpadd_limb_sel
    import mpadd_pkg::*;
#(
    parameter int LIMBS = 4
) (
    input  logic [LIMB_W*LIMBS-1:0]  vec_i,
    input  logic [$clog2(LIMBS)-1:0] k_i,
    output logic [LIMB_W-1:0]        limb_o
);
    assign limb_o = vec_i[k_i*LIMB_W +: LIMB_W];
endmodule

// File: rtl/mpadd_seq.sv
// mpadd_seq: feeds LIMBS x 64-bit operands limb by limb through an external 1-cycle adder, chaining carries.
// Build option MPADD_SUB_EN enables subtraction via in_op; otherwise every transaction is an add.
module mpadd_seq
    import mpadd_pkg::*;
#(
    parameter int LIMBS = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LIMB_W*LIMBS-1:0] in_a,
    input  logic [LIMB_W*LIMBS-1:0] in_b,
    input  logic                    in_op,
    input  logic                    in_carry,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LIMB_W*LIMBS-1:0] out_sum,
    output logic                    out_carry,
    output logic                    out_overflow,
    output logic [LIMB_W-1:0]       add_a,
    output logic [LIMB_W-1:0]       add_b,
    output logic                    add_carry,
    input  logic [LIMB_W-1:0]       add_s,
    input  logic                    add_overflow
);
    localparam int W  = LIMB_W*LIMBS;
    localparam int KW = $clog2(LIMBS);
    localparam logic [KW-1:0] LAST = KW'(LIMBS-1);

    state_t state_q, state_d;
    logic [W-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [KW-1:0] k_q, k_d;
    logic carry_q, carry_d, ovf_q, ovf_d;
    logic [W-1:0] b_in;
    logic c_in, busy, limb_co;
    logic [LIMB_W-1:0] la, lb;

`ifdef MPADD_SUB_EN
    assign b_in = (in_op == OP_SUB) ? ~in_b : in_b;
    assign c_in = (in_op == OP_SUB) ? ~in_carry : in_carry;
`else
    logic unused_op;
    assign unused_op = in_op;
    assign b_in = in_b;
    assign c_in = in_carry;
`endif

    mpadd_limb_sel #(.LIMBS(LIMBS)) u_sel_a (.vec_i(a_q), .k_i(k_q), .limb_o(la));
    mpadd_limb_sel #(.LIMBS(LIMBS)) u_sel_b (.vec_i(b_q), .k_i(k_q), .limb_o(lb));

    assign busy         = (state_q == ISSUE) || (state_q == CAPTURE);
    assign in_ready     = (state_q == IDLE);
    assign out_valid    = (state_q == DONE);
    assign out_sum      = sum_q;
    assign out_carry    = carry_q;
    assign out_overflow = ovf_q;
    assign add_a        = busy ? la : '0;
    assign add_b        = busy ? lb : '0;
    assign add_carry    = busy & carry_q;
    // Carry-out recovered from the sum MSB so the adder need not export it
    assign limb_co      = (la[LIMB_W-1] & lb[LIMB_W-1]) | ((la[LIMB_W-1] ^ lb[LIMB_W-1]) & ~add_s[LIMB_W-1]);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        k_d     = k_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (in_valid) begin
                a_d     = in_a;
                b_d     = b_in;
                carry_d = c_in;
                k_d     = '0;
                state_d = ISSUE;
            end
            ISSUE: state_d = CAPTURE;
            CAPTURE: begin
                sum_d[k_q*LIMB_W +: LIMB_W] = add_s;
                carry_d = limb_co;
                if (k_q == LAST) begin
                    ovf_d   = add_overflow;
                    state_d = DONE;
                end else begin
                    k_d     = k_q + KW'(1);
                    state_d = ISSUE;
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            k_q     <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_mpadd_seq.sv
// tb_mpadd_seq: scoreboard bench for mpadd_seq with a behavioural 1-cycle 64-bit adder.
module tb_mpadd_seq;
    localparam int LIMBS = 4;
    localparam int W = 64*LIMBS;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         carry;
        logic         ovf;
    } exp_t;

    logic clk = 0, rstn = 0;
    logic in_valid = 0, in_ready, in_op = 0, in_carry = 0;
    logic [W-1:0] in_a = '0, in_b = '0, out_sum;
    logic out_valid, out_ready = 1, out_carry, out_overflow;
    logic [63:0] add_a, add_b, add_s, add_nxt;
    logic add_carry, add_overflow;

    int checks = 0, errors = 0, cyc = 0, acc_cyc = 0;
    exp_t exp_q[$];
    exp_t e;

    mpadd_seq #(.LIMBS(LIMBS)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_carry(in_carry),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_carry(out_carry), .out_overflow(out_overflow),
        .add_a(add_a), .add_b(add_b), .add_carry(add_carry),
        .add_s(add_s), .add_overflow(add_overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign add_nxt = add_a + add_b + {63'b0, add_carry};
    always @(posedge clk) begin
        add_s        <= add_nxt;
        add_overflow <= (add_a[63] == add_b[63]) && (add_nxt[63] != add_a[63]);
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic op, input logic cin);
        logic [W:0] s;
        exp_t r;
        logic sub;
`ifdef MPADD_SUB_EN
        sub = op;
`else
        sub = 1'b0;
`endif
        if (sub) begin
            s = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin};
            r.carry = ~s[W];
            r.ovf   = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
        end else begin
            s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            r.carry = s[W];
            r.ovf   = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        end
        r.sum = s[W-1:0];
        return r;
    endfunction

    function automatic logic [W-1:0] rnd();
        logic [W-1:0] r = '0;
        for (int i = 0; i < W/32; i++) r = {r[W-33:0], 32'($urandom())};
        return r;
    endfunction

    always @(negedge clk) begin
        if (rstn && out_valid && out_ready) begin
            if (exp_q.size() == 0) check("sb_unexpected", 1, 0);
            else begin
                e = exp_q.pop_front();
                check("sum", out_sum, e.sum);
                check("carry", W'(out_carry), W'(e.carry));
                check("ovf", W'(out_overflow), W'(e.ovf));
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic op, input logic cin);
        int n = 0;
        in_a = a; in_b = b; in_op = op; in_carry = cin; in_valid = 1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("accept_timeout", 0, 1);
        else begin
            @(posedge clk);
            #1;
            acc_cyc = cyc;
            exp_q.push_back(model(a, b, op, cin));
        end
        in_valid = 0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) check("valid_timeout", 0, 1);
        else begin
            check("latency", W'(cyc - acc_cyc), W'(2*LIMBS));
            check("add_a_done", W'(add_a), 0);
        end
    endtask

    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic op, input logic cin);
        send(a, b, op, cin);
        wait_valid();
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] snap, ra;
    logic snap_c, snap_o;

    initial begin
        #12;
        check("rst_in_ready", W'(in_ready), 1);
        check("rst_out_valid", W'(out_valid), 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_carry", W'(out_carry), 0);
        check("rst_out_ovf", W'(out_overflow), 0);
        check("rst_add_a", W'(add_a), 0);
        check("rst_add_b", W'(add_b), 0);
        check("rst_add_carry", W'(add_carry), 0);
        @(negedge clk);
        rstn = 1;
        @(posedge clk);
        #1;
        run(W'({64{1'b1}}), W'(1), 0, 0);
        run({W{1'b1}}, W'(1), 0, 0);
        run({1'b0, {(W-1){1'b1}}}, W'(1), 0, 0);
        send(W'(0), W'(1), 1, 0);
        wait_valid();
`ifdef MPADD_SUB_EN
        check("sub_const", out_sum, {W{1'b1}});
`else
        check("sub_const", out_sum, W'(1));
`endif
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) run(rnd(), rnd(), i[0], i[1]);
        // Backpressure with a second operand waiting
        out_ready = 0;
        send(rnd(), rnd(), 0, 1);
        wait_valid();
        snap = out_sum; snap_c = out_carry; snap_o = out_overflow;
        ra = rnd();
        in_a = ra; in_b = W'(3); in_op = 0; in_carry = 0; in_valid = 1;
        repeat (5) begin
            @(negedge clk);
            check("bp_valid", W'(out_valid), 1);
            check("bp_sum", out_sum, snap);
            check("bp_flags", W'({out_carry, out_overflow}), W'({snap_c, snap_o}));
            check("bp_in_ready", W'(in_ready), 0);
        end
        @(posedge clk);
        #1 out_ready = 1;
        @(posedge clk);
        #1;
        check("b2b_in_ready", W'(in_ready), 1);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        exp_q.push_back(model(ra, W'(3), 0, 0));
        check("b2b_accepted", W'(in_ready), 0);
        in_valid = 0;
        wait_valid();
        @(posedge clk);
        #1;
        // Reset while limb 2 is being issued
        ra = {64'h1111, 64'hABCD_0123_4567_89EF, 64'h2222, 64'h3333};
        send(ra, rnd(), 0, 0);
        repeat (4) @(posedge clk);
        #1;
        check("limb2_add_a", W'(add_a), W'(ra[191:128]));
        #1 rstn = 0;
        #1;
        exp_q.delete();
        check("mid_rst_valid", W'(out_valid), 0);
        check("mid_rst_ready", W'(in_ready), 1);
        check("mid_rst_add", W'({add_a, add_b, add_carry}), 0);
        check("mid_rst_sum", out_sum, 0);
        @(negedge clk);
        rstn = 1;
        @(posedge clk);
        #1;
        send(W'(5), W'(7), 0, 0);
        wait_valid();
        check("post_rst_sum", out_sum, W'(12));
        @(posedge clk);
        #1;
        repeat (3) @(posedge clk);
        check("sb_drained", W'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end
endmodule
